// File: rtl/vtg_pkg.sv
// Shared types and MDA default timing for the video timing generator.
package vtg_pkg;

    // Horizontal region a pixel position falls into.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } vtg_region_e;

    // Lengths of the four regions along one axis.
    typedef struct packed {
        logic [31:0] active;
        logic [31:0] fp;
        logic [31:0] sync;
        logic [31:0] bp;
    } vtg_axis_t;

    // Complete raster description.
    typedef struct packed {
        vtg_axis_t h;
        vtg_axis_t v;
    } vtg_timing_t;

    localparam int unsigned MDA_H_ACTIVE = 720;
    localparam int unsigned MDA_H_FP     = 10;
    localparam int unsigned MDA_H_SYNC   = 135;
    localparam int unsigned MDA_H_BP     = 17;
    localparam int unsigned MDA_V_ACTIVE = 350;
    localparam int unsigned MDA_V_FP     = 0;
    localparam int unsigned MDA_V_SYNC   = 16;
    localparam int unsigned MDA_V_BP     = 4;
    localparam int unsigned MDA_INC_RST  = 1396465667;

    // Total positions along one axis.
    function automatic int unsigned vtg_axis_total(input vtg_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Increment-load inputs and raster outputs of video_timing_gen.
// ext_sync exists only when VTG_GENLOCK_EN is defined.
interface video_timing_gen_if #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned ACC_W = 32
);
    logic [ACC_W-1:0] inc_in;
    logic             inc_load;
`ifdef VTG_GENLOCK_EN
    logic             ext_sync;
`endif
    logic             pix_ce;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             valid;
    logic             hsync;
    logic             vsync;
    logic             newline;
    logic             newframe;

    modport master (
        input  inc_in,
        input  inc_load,
`ifdef VTG_GENLOCK_EN
        input  ext_sync,
`endif
        output pix_ce,
        output x,
        output y,
        output valid,
        output hsync,
        output vsync,
        output newline,
        output newframe
    );

    modport slave (
        output inc_in,
        output inc_load,
`ifdef VTG_GENLOCK_EN
        output ext_sync,
`endif
        input  pix_ce,
        input  x,
        input  y,
        input  valid,
        input  hsync,
        input  vsync,
        input  newline,
        input  newframe
    );
endinterface

// File: rtl/vtg_phase_acc.sv
// Phase accumulator producing the pixel clock enable. The increment is
// double-buffered: loads land in a shadow and reach the accumulator only at
// a frame start, so the pixel rate is constant within a frame.
module vtg_phase_acc
    import vtg_pkg::*;
#(
    parameter int unsigned       ACC_W   = 32,
    parameter logic [ACC_W-1:0]  INC_RST = ACC_W'(MDA_INC_RST)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] i_inc_in,
    input  logic             i_inc_load,
    input  logic             i_frame_start,
    output logic             o_pix_ce
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_shadow;
    logic [ACC_W-1:0] r_inc_act;
    logic             r_pix_ce;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc_act};

    // Accumulate every cycle; the carry becomes the next-cycle pixel enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_pix_ce  <= 1'b0;
            r_shadow  <= INC_RST;
            r_inc_act <= INC_RST;
        end else begin
            r_acc    <= w_sum[ACC_W-1:0];
            r_pix_ce <= w_sum[ACC_W];
            // The active rate takes the shadow as it was before any same-cycle load.
            if (i_frame_start) begin
                r_inc_act <= r_shadow;
            end
            if (i_inc_load) begin
                r_shadow <= i_inc_in;
            end
        end
    end

    assign o_pix_ce = r_pix_ce;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters advanced by a phase-accumulator
// pixel enable, with sync/valid decodes and line/frame start pulses.
// Optional genlock input is built when VTG_GENLOCK_EN is defined.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned      H_ACTIVE = MDA_H_ACTIVE,
    parameter int unsigned      H_FP     = MDA_H_FP,
    parameter int unsigned      H_SYNC   = MDA_H_SYNC,
    parameter int unsigned      H_BP     = MDA_H_BP,
    parameter int unsigned      V_ACTIVE = MDA_V_ACTIVE,
    parameter int unsigned      V_FP     = MDA_V_FP,
    parameter int unsigned      V_SYNC   = MDA_V_SYNC,
    parameter int unsigned      V_BP     = MDA_V_BP,
    parameter bit               HS_POL   = 1'b1,
    parameter bit               VS_POL   = 1'b0,
    parameter int unsigned      CNT_W    = 10,
    parameter int unsigned      ACC_W    = 32,
    parameter logic [ACC_W-1:0] INC_RST  = ACC_W'(MDA_INC_RST)
) (
    input  logic               clk,
    input  logic               rst,
    video_timing_gen_if.master bus
);

    localparam vtg_timing_t TIMING = '{
        h: '{active: 32'(H_ACTIVE), fp: 32'(H_FP), sync: 32'(H_SYNC), bp: 32'(H_BP)},
        v: '{active: 32'(V_ACTIVE), fp: 32'(V_FP), sync: 32'(V_SYNC), bp: 32'(V_BP)}
    };
    localparam int unsigned H_TOT = vtg_axis_total(TIMING.h);
    localparam int unsigned V_TOT = vtg_axis_total(TIMING.v);
    localparam int unsigned CMP_W = CNT_W + 1;

    // Region boundaries, one bit wider than the counters so a full 2**CNT_W span fits.
    localparam logic [CNT_W:0] H_FP_START   = CMP_W'(H_ACTIVE);
    localparam logic [CNT_W:0] H_SYNC_START = CMP_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] H_BP_START   = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_FP_START   = CMP_W'(V_ACTIVE);
    localparam logic [CNT_W:0] V_SYNC_START = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] V_BP_START   = CMP_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [63:0]    CNT_SPAN     = 64'(1) << CNT_W;

    // Reject rasters the counters cannot represent.
    if (64'(H_TOT) > CNT_SPAN) begin : g_err_h_tot
        $error("video_timing_gen: H_TOT exceeds 2**CNT_W");
    end
    if (64'(V_TOT) > CNT_SPAN) begin : g_err_v_tot
        $error("video_timing_gen: V_TOT exceeds 2**CNT_W");
    end
    if (H_ACTIVE == 0) begin : g_err_h_active
        $error("video_timing_gen: H_ACTIVE must be non-zero");
    end
    if (V_ACTIVE == 0) begin : g_err_v_active
        $error("video_timing_gen: V_ACTIVE must be non-zero");
    end

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_newline;
    logic             r_newframe;
    vtg_region_e      r_hregion;

    logic [CNT_W-1:0] w_x_next;
    logic [CNT_W-1:0] w_y_next;
    logic             w_newline_next;
    logic             w_newframe_next;
    vtg_region_e      w_hregion_next;
    logic             w_pix_ce;
    logic             w_resync;
    logic             w_h_end;
    logic             w_v_end;

    // Region of a horizontal position; zero-length regions are never returned.
    function automatic vtg_region_e h_region_of(input logic [CNT_W-1:0] xv);
        logic [CNT_W:0] xw;
        xw = {1'b0, xv};
        if (xw < H_FP_START) begin
            return ACTIVE;
        end else if (xw < H_SYNC_START) begin
            return FP;
        end else if (xw < H_BP_START) begin
            return SYNC;
        end
        return BP;
    endfunction

    vtg_phase_acc #(
        .ACC_W   (ACC_W),
        .INC_RST (INC_RST)
    ) u_phase_acc (
        .clk           (clk),
        .rst           (rst),
        .i_inc_in      (bus.inc_in),
        .i_inc_load    (bus.inc_load),
        .i_frame_start (w_newframe_next),
        .o_pix_ce      (w_pix_ce)
    );

`ifdef VTG_GENLOCK_EN
    logic r_sync_pend;

    // Hold a genlock request until the next pixel tick services it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_pend <= 1'b0;
        end else begin
            r_sync_pend <= (r_sync_pend & ~w_pix_ce) | bus.ext_sync;
        end
    end

    assign w_resync = w_pix_ce & r_sync_pend;
`else
    assign w_resync = 1'b0;
`endif

    assign w_h_end = (r_x == CNT_W'(H_TOT - 1));
    assign w_v_end = (r_y == CNT_W'(V_TOT - 1));

    // Counter next state; a genlock restart and a natural wrap yield the same pulse pair.
    always_comb begin
        w_x_next        = r_x;
        w_y_next        = r_y;
        w_newline_next  = 1'b0;
        w_newframe_next = 1'b0;
        if (w_pix_ce) begin
            if (w_resync) begin
                w_x_next        = '0;
                w_y_next        = '0;
                w_newline_next  = 1'b1;
                w_newframe_next = 1'b1;
            end else if (w_h_end) begin
                w_x_next       = '0;
                w_newline_next = 1'b1;
                if (w_v_end) begin
                    w_y_next        = '0;
                    w_newframe_next = 1'b1;
                end else begin
                    w_y_next = r_y + CNT_W'(1);
                end
            end else begin
                w_x_next = r_x + CNT_W'(1);
            end
        end
    end

    // Counter and pulse registers; reset leaves both start pulses asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_newline  <= 1'b1;
            r_newframe <= 1'b1;
        end else begin
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_newline  <= w_newline_next;
            r_newframe <= w_newframe_next;
        end
    end

    // Horizontal region next state, tracking the position x is about to take.
    always_comb begin
        w_hregion_next = r_hregion;
        if (w_pix_ce) begin
            w_hregion_next = h_region_of(w_x_next);
        end
    end

    // Horizontal region state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hregion <= h_region_of(CNT_W'(0));
        end else begin
            r_hregion <= w_hregion_next;
        end
    end

    assign bus.pix_ce   = w_pix_ce;
    assign bus.x        = r_x;
    assign bus.y        = r_y;
    assign bus.newline  = r_newline;
    assign bus.newframe = r_newframe;
    assign bus.valid    = ({1'b0, r_x} < H_FP_START) && ({1'b0, r_y} < V_FP_START);
    assign bus.hsync    = (r_hregion == SYNC) ? HS_POL : ~HS_POL;
    assign bus.vsync    = (({1'b0, r_y} >= V_SYNC_START) && ({1'b0, r_y} < V_BP_START))
                          ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small raster and the MDA default raster run
// side by side against a frame-position reference model through scoreboards.
// Define VTG_GENLOCK_EN to also exercise the genlock input.
module tb_video_timing_gen;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned ACC_W = 32;
    localparam int          N_CYC = 5000;

    typedef struct {
        int unsigned     ha, hf, hs, hb, va, vf, vs, vb;
        bit              hpol, vpol;
        longint unsigned inc_rst;
    } cfg_t;

    // Model state: position is a linear pixel index within the frame.
    typedef struct {
        longint unsigned acc, act, shadow;
        int unsigned     pos;
        bit              pix, nl, nf, pend;
    } mdl_t;

    typedef struct {
        int pix, x, y, valid, hs, vs, nl, nf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_s, rst_m;
    always #5 clk = ~clk;

    video_timing_gen_if #(.CNT_W(CNT_W), .ACC_W(ACC_W)) if_s ();
    video_timing_gen_if #(.CNT_W(CNT_W), .ACC_W(ACC_W)) if_m ();

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0),
        .CNT_W(CNT_W), .ACC_W(ACC_W), .INC_RST(32'h8000_0000)
    ) dut_s (
        .clk(clk), .rst(rst_s), .bus(if_s.master)
    );

    video_timing_gen #(
        .CNT_W(CNT_W), .ACC_W(ACC_W)
    ) dut_m (
        .clk(clk), .rst(rst_m), .bus(if_m.master)
    );

    cfg_t cfg_s, cfg_m;
    mdl_t mdl_s, mdl_m;
    exp_t q_s[$];
    exp_t q_m[$];
    exp_t e_s, e_m;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned h_tot(input cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int unsigned f_tot(input cfg_t c);
        return h_tot(c) * (c.va + c.vf + c.vs + c.vb);
    endfunction

    // One clock edge of the reference behaviour.
    function automatic mdl_t mdl_step(input cfg_t c, input mdl_t m_in, input bit rst,
                                      input bit load, input longint unsigned inc, input bit ext);
        mdl_t m = m_in;
        longint unsigned sum;
        if (rst) begin
            m.acc = 0; m.pix = 0; m.pos = 0; m.pend = 0;
            m.shadow = c.inc_rst; m.act = c.inc_rst;
            m.nl = 1; m.nf = 1;
            return m;
        end
        sum  = m.acc + m.act;
        m.nl = 0;
        m.nf = 0;
        if (m.pix) begin
            m.pos = m.pend ? 0 : (m.pos + 1) % f_tot(c);
            m.nl  = (m.pos % h_tot(c)) == 0;
            m.nf  = (m.pos == 0);
        end
        if (m.nf) m.act = m.shadow;
        if (load) m.shadow = inc;
        m.pend = (m.pend && !m.pix) || ext;
        m.acc  = sum % (64'd1 << 32);
        m.pix  = (sum >> 32) != 0;
        return m;
    endfunction

    function automatic exp_t mdl_out(input cfg_t c, input mdl_t m);
        exp_t e;
        e.x     = int'(m.pos % h_tot(c));
        e.y     = int'(m.pos / h_tot(c));
        e.pix   = int'(m.pix);
        e.nl    = int'(m.nl);
        e.nf    = int'(m.nf);
        e.valid = int'(e.x < int'(c.ha) && e.y < int'(c.va));
        e.hs    = int'((e.x >= int'(c.ha + c.hf) && e.x < int'(c.ha + c.hf + c.hs)) ? c.hpol : !c.hpol);
        e.vs    = int'((e.y >= int'(c.va + c.vf) && e.y < int'(c.va + c.vf + c.vs)) ? c.vpol : !c.vpol);
        return e;
    endfunction

    // True when the coming edge performs a natural frame wrap.
    function automatic bit wraps_next(input cfg_t c, input mdl_t m);
        return m.pix && !m.pend && ((m.pos + 1) % f_tot(c)) == 0;
    endfunction

    // Stimulus: choose inputs, advance the models, queue the expected outputs.
    initial begin
        bit              rs, ld, ex, coinc_done, m_rst_done, gl1_done, gl2_done, m_gl_done;
        logic [31:0]     inc;
        exp_t            cur;
        cfg_s = '{ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1,
                  hpol:1'b1, vpol:1'b0, inc_rst:64'h8000_0000};
        cfg_m = '{ha:720, hf:10, hs:135, hb:17, va:350, vf:0, vs:16, vb:4,
                  hpol:1'b1, vpol:1'b0, inc_rst:64'd1396465667};
        mdl_s = '{default:0};
        mdl_m = '{default:0};
        coinc_done = 0; m_rst_done = 0; gl1_done = 0; gl2_done = 0; m_gl_done = 0;
        for (int c = 0; c < N_CYC; c++) begin
            // small raster
            rs = 0; ld = 0; ex = 0; inc = '0;
            if (c < 3) begin
                rs = 1;
            end else if (c == 150) begin
                ld = 1; inc = 32'h4000_0000;
            end else if (c > 400 && !coinc_done && wraps_next(cfg_s, mdl_s)) begin
                ld = 1; inc = 32'h8000_0000; coinc_done = 1;
            end else if (c >= 800 && c < 1300) begin
                if ($urandom_range(0, 39) == 0) begin
                    ld = 1;
                    case ($urandom_range(0, 3))
                        0:       inc = 32'h8000_0000;
                        1:       inc = 32'h4000_0000;
                        2:       inc = 32'hC000_0000;
                        default: inc = $urandom | 32'h4000_0000;
                    endcase
                end
                if ($urandom_range(0, 299) == 0) rs = 1;
`ifdef VTG_GENLOCK_EN
                if ($urandom_range(0, 59) == 0) ex = 1;
`endif
            end else if (c == 1300) begin
                ld = 1; inc = 32'h0;
            end else if (c == 2400) begin
                rs = 1;
            end
`ifdef VTG_GENLOCK_EN
            if (c >= 560 && c < 800 && !gl1_done && mdl_s.pos == 10 && !mdl_s.pend) begin
                ex = 1; gl1_done = 1;
            end else if (c >= 560 && c < 800 && gl1_done && !gl2_done && !mdl_s.pend
                         && !mdl_s.pix && mdl_s.pos == f_tot(cfg_s) - 1) begin
                ex = 1; gl2_done = 1;
            end
            if_s.ext_sync = ex;
`endif
            rst_s = rs; if_s.inc_load = ld; if_s.inc_in = inc;
            mdl_s = mdl_step(cfg_s, mdl_s, rs, ld, 64'(inc), ex);
            q_s.push_back(mdl_out(cfg_s, mdl_s));

            // MDA raster
            rs = 0; ld = 0; ex = 0; inc = '0;
            cur = mdl_out(cfg_m, mdl_m);
            if (c < 3) begin
                rs = 1;
            end else if (c >= 3000 && !m_rst_done && cur.x == 400) begin
                rs = 1; m_rst_done = 1;
            end else if (c == 1000) begin
                ld = 1; inc = 32'hFFFF_FFFF;
            end
`ifdef VTG_GENLOCK_EN
            if (c >= 4200 && !m_gl_done && cur.x == 100 && !rs) begin
                ex = 1; m_gl_done = 1;
            end
            if_m.ext_sync = ex;
`endif
            rst_m = rs; if_m.inc_load = ld; if_m.inc_in = inc;
            mdl_m = mdl_step(cfg_m, mdl_m, rs, ld, 64'(inc), ex);
            q_m.push_back(mdl_out(cfg_m, mdl_m));

            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("s_queue_drained", q_s.size(), 0);
        chk("m_queue_drained", q_m.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    int cyc_s = 0, nf_cyc_s = 0, nat_nf_s = 0, pix_cnt_s = 0;

    // Small-raster monitor: scoreboard plus frame length in clocks and ticks.
    always @(posedge clk) begin
        #1;
        if (q_s.size() != 0) begin
            e_s = q_s.pop_front();
            chk("s_pix_ce",   int'(if_s.pix_ce),   e_s.pix);
            chk("s_x",        int'(if_s.x),        e_s.x);
            chk("s_y",        int'(if_s.y),        e_s.y);
            chk("s_valid",    int'(if_s.valid),    e_s.valid);
            chk("s_hsync",    int'(if_s.hsync),    e_s.hs);
            chk("s_vsync",    int'(if_s.vsync),    e_s.vs);
            chk("s_newline",  int'(if_s.newline),  e_s.nl);
            chk("s_newframe", int'(if_s.newframe), e_s.nf);
        end
        cyc_s++;
        if (!rst_s && if_s.newframe && nat_nf_s < 2) begin
            nat_nf_s++;
            if (nat_nf_s == 2) begin
                chk("s_frame_clocks", cyc_s - nf_cyc_s, 96);
                chk("s_frame_ticks",  pix_cnt_s, 48);
            end
            nf_cyc_s  = cyc_s;
            pix_cnt_s = 0;
        end
        pix_cnt_s += int'(if_s.pix_ce);
    end

    int  pix_cnt_m = 0;
    bit  line_done_m = 0;

    // MDA monitor: scoreboard plus line length and fixed sync/valid edges.
    always @(posedge clk) begin
        #1;
        if (q_m.size() != 0) begin
            e_m = q_m.pop_front();
            chk("m_pix_ce",   int'(if_m.pix_ce),   e_m.pix);
            chk("m_x",        int'(if_m.x),        e_m.x);
            chk("m_y",        int'(if_m.y),        e_m.y);
            chk("m_valid",    int'(if_m.valid),    e_m.valid);
            chk("m_hsync",    int'(if_m.hsync),    e_m.hs);
            chk("m_vsync",    int'(if_m.vsync),    e_m.vs);
            chk("m_newline",  int'(if_m.newline),  e_m.nl);
            chk("m_newframe", int'(if_m.newframe), e_m.nf);
        end
        if (if_m.newline) begin
            if (!rst_m && !line_done_m) begin
                chk("m_line_ticks", pix_cnt_m, 882);
                line_done_m = 1;
            end
            pix_cnt_m = 0;
        end
        pix_cnt_m += int'(if_m.pix_ce);
        if (!rst_m) begin
            case (int'(if_m.x))
                719: chk("m_valid_x719", int'(if_m.valid), 1);
                720: chk("m_valid_x720", int'(if_m.valid), 0);
                729: chk("m_hsync_x729", int'(if_m.hsync), 0);
                730: chk("m_hsync_x730", int'(if_m.hsync), 1);
                864: chk("m_hsync_x864", int'(if_m.hsync), 1);
                865: chk("m_hsync_x865", int'(if_m.hsync), 0);
                default: ;
            endcase
        end
    end

endmodule
